// File: rtl/spmmio_initiator.sv
// Wishbone classic initiator for the spmmio space: valid/ready commands in, one response per beat out.
// Optional stuck-beat abort is built when SPMMIO_INIT_TIMEOUT_EN is defined.
module spmmio_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [0:21] cmd_adr,
    input  logic        cmd_we,
    input  logic [0:3]  cmd_sel,
    input  logic [0:31] cmd_dat,
    input  logic [0:7]  cmd_len,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [0:31] rsp_dat,
    output logic        rsp_err,
    output logic        rsp_last,
    output logic        busy,
    output logic [0:23] adr_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic [0:3]  sel_o,
    output logic        we_o,
    output logic [0:31] dat_o,
    input  logic        ack_i,
    input  logic [0:31] dat_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;
    logic [0:21] adr_q, adr_d;
    logic        we_q, we_d;
    logic [0:3]  sel_q, sel_d;
    logic [0:31] dat_q, dat_d;
    logic [0:7]  rem_q, rem_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [0:31] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_last_q, rsp_last_d;
    logic        accept_s;
    logic        timeout_s;

    if ((2 ** CNT_W) < TIMEOUT_CYCLES) begin : g_cnt_w_too_small
    end

    assign accept_s = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;

`ifdef SPMMIO_INIT_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout_s = (state_q == S_BUS) && !ack_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Wait-cycle counter: zero outside BUS, so every beat starts counting from zero
    always_comb begin
        if ((state_q == S_BUS) && !ack_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = CNT_W'(0);
        end
    end

    // Wait-cycle counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= CNT_W'(0);
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            adr_q       <= 22'd0;
            we_q        <= 1'b0;
            sel_q       <= 4'd0;
            dat_q       <= 32'd0;
            rem_q       <= 8'd0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 32'd0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            adr_q       <= adr_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            dat_q       <= dat_d;
            rem_q       <= rem_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) state_d = S_BUS;
                else          state_d = S_IDLE;
            end
            S_BUS: begin
                if (ack_i || timeout_s) state_d = S_RESP;
                else                    state_d = S_BUS;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    if (rem_q != 8'd0) state_d = S_BUS;
                    else               state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; the abort path zeroes the remaining count so RESP falls back to IDLE
    always_comb begin
        adr_d       = adr_q;
        we_d        = we_q;
        sel_d       = sel_q;
        dat_d       = dat_q;
        rem_d       = rem_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        rsp_last_d  = rsp_last_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    adr_d = cmd_adr;
                    we_d  = cmd_we;
                    sel_d = cmd_sel;
                    dat_d = cmd_dat;
                    rem_d = cmd_len;
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                end else begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                end
            end
            S_BUS: begin
                if (ack_i) begin
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = we_q ? 32'd0 : dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_last_d  = (rem_q == 8'd0);
                end else if (timeout_s) begin
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = 32'd0;
                    rsp_err_d   = 1'b1;
                    rsp_last_d  = 1'b1;
                    rem_d       = 8'd0;
                end else begin
                    stb_d = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_dat_d   = 32'd0;
                    rsp_err_d   = 1'b0;
                    rsp_last_d  = 1'b0;
                    if (rem_q != 8'd0) begin
                        rem_d = rem_q - 8'd1;
                        adr_d = adr_q + 22'd1;
                        stb_d = 1'b1;
                    end else begin
                        cyc_d = 1'b0;
                    end
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign adr_o     = {adr_q, 2'b00};
    assign we_o      = we_q;
    assign sel_o     = sel_q;
    assign dat_o     = dat_q;
    assign cyc_o     = cyc_q;
    assign stb_o     = stb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_spmmio_initiator.sv
// Directed bench for spmmio_initiator with a response scoreboard and a beat-address log.
module tb_spmmio_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [0:21] cmd_adr;
    logic        cmd_we;
    logic [0:3]  cmd_sel;
    logic [0:31] cmd_dat;
    logic [0:7]  cmd_len;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:31] rsp_dat;
    logic        rsp_err;
    logic        rsp_last;
    logic        busy;
    logic [0:23] adr_o;
    logic        cyc_o;
    logic        stb_o;
    logic [0:3]  sel_o;
    logic        we_o;
    logic [0:31] dat_o;
    logic        ack_i;
    logic [0:31] dat_i;

    logic        ack_en;
    logic [31:0] rd_data;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        logic        last;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [23:0] exp_adr_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int stb_cnt  = 0;
    int acc_cnt  = 0;
    int beat_wr  = 0;
    int beat_rd  = 0;
    logic [23:0] beat_adr [0:63];

    spmmio_initiator dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_adr(cmd_adr), .cmd_we(cmd_we),
        .cmd_sel(cmd_sel), .cmd_dat(cmd_dat), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .rsp_last(rsp_last), .busy(busy),
        .adr_o(adr_o), .cyc_o(cyc_o), .stb_o(stb_o), .sel_o(sel_o), .we_o(we_o), .dat_o(dat_o),
        .ack_i(ack_i), .dat_i(dat_i)
    );

    always #5 clk = ~clk;

    // Zero-wait target: acks in the same cycle as the strobe when enabled
    assign ack_i = ack_en && cyc_o && stb_o;
    assign dat_i = ack_i ? rd_data : 32'h0;

    always @(posedge clk) begin
        if (stb_o) stb_cnt <= stb_cnt + 1;
        if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
        if (cyc_o && stb_o && ack_i && beat_wr < 64) begin
            beat_adr[beat_wr] <= adr_o;
            beat_wr <= beat_wr + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_rsp(input logic [31:0] d, input logic e, input logic l);
        rsp_t r;
        r.dat = d;
        r.err = e;
        r.last = l;
        exp_q.push_back(r);
    endtask

    task automatic send_cmd(input logic [21:0] adr, input logic we, input logic [3:0] sel,
                            input logic [31:0] dat, input logic [7:0] len);
        int w = 0;
        cmd_adr = adr;
        cmd_we = we;
        cmd_sel = sel;
        cmd_dat = dat;
        cmd_len = len;
        cmd_valid = 1'b1;
        while (!cmd_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("cmd_accept", cmd_ready, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input int stall);
        int w = 0;
        rsp_t r;
        while (!rsp_valid && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_rsp_wait"}, rsp_valid, 32'd1);
        if (rsp_valid) begin
            for (int i = 0; i < stall; i++) begin
                check({tag, "_hold_cyc"}, cyc_o, 32'd1);
                check({tag, "_hold_stb"}, stb_o, 32'd0);
                check({tag, "_hold_valid"}, rsp_valid, 32'd1);
                @(negedge clk);
            end
            check({tag, "_sb_nonempty"}, (exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                check({tag, "_dat"}, rsp_dat, r.dat);
                check({tag, "_err"}, rsp_err, r.err);
                check({tag, "_last"}, rsp_last, r.last);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic check_beats(input string tag);
        check({tag, "_nbeats"}, beat_wr - beat_rd, exp_adr_q.size());
        while (exp_adr_q.size() != 0 && beat_rd < beat_wr) begin
            check({tag, "_adr"}, beat_adr[beat_rd], exp_adr_q.pop_front());
            beat_rd++;
        end
        exp_adr_q.delete();
        beat_rd = beat_wr;
    endtask

    initial begin
        logic [31:0] d6 [0:2];
        int s0;
        d6[0] = 32'h11110001;
        d6[1] = 32'h22220002;
        d6[2] = 32'h33330003;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_adr = 22'd0;
        cmd_we = 1'b0;
        cmd_sel = 4'd0;
        cmd_dat = 32'd0;
        cmd_len = 8'd0;
        rsp_ready = 1'b0;
        ack_en = 1'b1;
        rd_data = 32'h0;
        #1 reset = 1'b0;
        #2;
        check("rst_cmd_ready", cmd_ready, 32'd0);
        check("rst_cyc", cyc_o, 32'd0);
        check("rst_stb", stb_o, 32'd0);
        check("rst_rsp_valid", rsp_valid, 32'd0);
        check("rst_adr", adr_o, 32'd0);
        check("rst_busy", busy, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 32'd1);

        // 1: single read, same-cycle ack
        rd_data = 32'hDEADBEEF;
        push_rsp(32'hDEADBEEF, 1'b0, 1'b1);
        exp_adr_q.push_back(24'h100004);
        s0 = stb_cnt;
        send_cmd(22'h040001, 1'b0, 4'hF, 32'h0, 8'd0);
        get_rsp("t1", 0);
        check("t1_stb_cycles", stb_cnt - s0, 32'd1);
        check("t1_cyc_end", cyc_o, 32'd0);
        check_beats("t1");

        // 2: write burst with response backpressure
        rd_data = 32'hFFFFFFFF;
        for (int k = 0; k < 4; k++) begin
            push_rsp(32'h0, 1'b0, (k == 3));
            exp_adr_q.push_back(24'h140000 + 24'(4 * k));
        end
        send_cmd(22'h050000, 1'b1, 4'hF, 32'h12345678, 8'd3);
        for (int k = 0; k < 4; k++) begin
            get_rsp("t2", 5);
            if (k == 0) begin
                check("t2_we_o", we_o, 32'd1);
                check("t2_sel_o", sel_o, 32'hF);
                check("t2_dat_o", dat_o, 32'h12345678);
            end
        end
        check("t2_cyc_end", cyc_o, 32'd0);
        check_beats("t2");

        // 3: address wrap
        rd_data = 32'hCAFEF00D;
        push_rsp(32'hCAFEF00D, 1'b0, 1'b0);
        push_rsp(32'hCAFEF00D, 1'b0, 1'b1);
        exp_adr_q.push_back(24'hFFFFFC);
        exp_adr_q.push_back(24'h000000);
        send_cmd(22'h3FFFFF, 1'b0, 4'h3, 32'h0, 8'd1);
        get_rsp("t3a", 0);
        get_rsp("t3b", 1);
        check_beats("t3");

        // 4: target never acks
        ack_en = 1'b0;
        rd_data = 32'h0BADF00D;
`ifdef SPMMIO_INIT_TIMEOUT_EN
        push_rsp(32'h0, 1'b1, 1'b1);
        s0 = stb_cnt;
        send_cmd(22'h000123, 1'b0, 4'hF, 32'h0, 8'd2);
        get_rsp("t4", 0);
        check("t4_stb_cycles", stb_cnt - s0, 32'd256);
        check("t4_cyc_end", cyc_o, 32'd0);
        repeat (10) @(negedge clk);
        check("t4_no_more_stb", stb_cnt - s0, 32'd256);
        check("t4_idle", busy, 32'd0);
        ack_en = 1'b1;
        check_beats("t4");
`else
        push_rsp(32'h0BADF00D, 1'b0, 1'b1);
        exp_adr_q.push_back(24'h00048C);
        send_cmd(22'h000123, 1'b0, 4'hF, 32'h0, 8'd0);
        repeat (1000) @(negedge clk);
        check("t4_stb_held", stb_o, 32'd1);
        check("t4_no_rsp", rsp_valid, 32'd0);
        check("t4_not_ready", cmd_ready, 32'd0);
        ack_en = 1'b1;
        get_rsp("t4", 0);
        check_beats("t4");
`endif

        // 5: asynchronous reset in beat 2 of 4
        rd_data = 32'h55AA55AA;
        push_rsp(32'h55AA55AA, 1'b0, 1'b0);
        exp_adr_q.push_back(24'h004000);
        send_cmd(22'h001000, 1'b0, 4'hF, 32'h0, 8'd3);
        while (!rsp_valid) @(negedge clk);
        ack_en = 1'b0;
        get_rsp("t5", 0);
        check("t5_stb_beat2", stb_o, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t5_rst_cyc", cyc_o, 32'd0);
        check("t5_rst_stb", stb_o, 32'd0);
        check("t5_rst_valid", rsp_valid, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        ack_en = 1'b1;
        rd_data = 32'h76543210;
        push_rsp(32'h76543210, 1'b0, 1'b1);
        exp_adr_q.push_back(24'h008888);
        send_cmd(22'h002222, 1'b0, 4'hF, 32'h0, 8'd0);
        get_rsp("t5n", 0);
        check_beats("t5");

        // 6: cmd_valid held high across three single reads
        s0 = acc_cnt;
        for (int k = 0; k < 3; k++) begin
            push_rsp(d6[k], 1'b0, 1'b1);
            exp_adr_q.push_back(24'h000040);
        end
        rd_data = d6[0];
        cmd_adr = 22'h000010;
        cmd_we = 1'b0;
        cmd_len = 8'd0;
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            get_rsp("t6", 0);
            if (k < 2) rd_data = d6[k + 1];
            else       cmd_valid = 1'b0;
        end
        repeat (5) @(negedge clk);
        check("t6_accepts", acc_cnt - s0, 32'd3);
        check("t6_idle", busy, 32'd0);
        check_beats("t6");

        check("sb_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
